// File: rtl/req_gen.sv
// Two-channel request generator: rising strobe edges queue events in a saturating
// counter, each event is presented as one request and retired by one accepted grant.

module req_gen_chan #(
    parameter int CNT_W = 4,
    parameter int HOLD  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic             gnt,
    input  logic             clear_ovf,
    output logic             req,
    output logic [CNT_W-1:0] pend,
    output logic             ovf
);
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD > 0) ? HOLD - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              strobe_sampled;
    logic              armed;
    logic              armed_next;
    logic              req_next;
    logic [CNT_W-1:0]  pend_next;
    logic              ovf_next;
    logic              strobe_edge;
    logic              accept;

    assign strobe_edge = strobe & ~strobe_sampled;

    // A grant only counts once the arbiter has seen this request for a full cycle.
    assign accept = (state == ST_REQ) & armed & gnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            hold_cnt       <= '0;
            strobe_sampled <= 1'b0;
            armed          <= 1'b0;
            req            <= 1'b0;
            pend           <= '0;
            ovf            <= 1'b0;
        end else begin
            state          <= state_next;
            hold_cnt       <= hold_cnt_next;
            strobe_sampled <= strobe;
            armed          <= armed_next;
            req            <= req_next;
            pend           <= pend_next;
            ovf            <= ovf_next;
        end
    end

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (pend != '0) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (accept) begin
                    if (HOLD == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next    = ST_HOLD;
                        hold_cnt_next = HOLD_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    hold_cnt_next = hold_cnt - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_next   = (state_next == ST_REQ);
        armed_next = (state == ST_REQ) && !accept;
    end

    // A simultaneous edge and accept cancel out, even when the counter is full.
    always_comb begin
        pend_next = pend;
        ovf_next  = ovf & ~clear_ovf;
        if (strobe_edge && !accept) begin
            if (pend != PEND_MAX) begin
                pend_next = pend + 1'b1;
            end else begin
                ovf_next = 1'b1;
            end
        end else if (accept && !strobe_edge) begin
            pend_next = pend - 1'b1;
        end
    end
endmodule

module req_gen #(
    parameter int CNT_W = 4,
    parameter int HOLD  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe_0,
    input  logic             strobe_1,
    input  logic             gnt_0,
    input  logic             gnt_1,
    input  logic             clear_ovf,
    output logic             req_0,
    output logic             req_1,
    output logic [CNT_W-1:0] pend_0,
    output logic [CNT_W-1:0] pend_1,
    output logic             ovf_0,
    output logic             ovf_1
);
    req_gen_chan #(
        .CNT_W (CNT_W),
        .HOLD  (HOLD)
    ) u_chan_0 (
        .clock     (clock),
        .reset     (reset),
        .strobe    (strobe_0),
        .gnt       (gnt_0),
        .clear_ovf (clear_ovf),
        .req       (req_0),
        .pend      (pend_0),
        .ovf       (ovf_0)
    );

    req_gen_chan #(
        .CNT_W (CNT_W),
        .HOLD  (HOLD)
    ) u_chan_1 (
        .clock     (clock),
        .reset     (reset),
        .strobe    (strobe_1),
        .gnt       (gnt_1),
        .clear_ovf (clear_ovf),
        .req       (req_1),
        .pend      (pend_1),
        .ovf       (ovf_1)
    );
endmodule

// File: tb/tb_req_gen.sv
// Bench for req_gen: a registered fixed-priority arbiter model (or forced grants)
// drives the grant inputs while an event-count scoreboard tracks pend/ovf.

module tb_req_gen;
    localparam int CNT_W = 4;
    localparam int HOLD  = 2;
    localparam int PMAX  = 15;

    logic             clock = 1'b0;
    logic             reset;
    logic             strobe_0;
    logic             strobe_1;
    logic             gnt_0;
    logic             gnt_1;
    logic             clear_ovf;
    logic             req_0;
    logic             req_1;
    logic [CNT_W-1:0] pend_0;
    logic [CNT_W-1:0] pend_1;
    logic             ovf_0;
    logic             ovf_1;

    logic arb_on;
    logic gnt_force_0;
    logic gnt_force_1;

    int checks = 0;
    int fails  = 0;

    int m_pend[2];
    int m_pend_prev[2];
    bit m_ovf[2];
    bit prev_s[2];
    bit req_seen[2];
    int since_acc[2];
    int acc_cnt[2];
    int acc_q[$];

    req_gen #(
        .CNT_W (CNT_W),
        .HOLD  (HOLD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .strobe_0  (strobe_0),
        .strobe_1  (strobe_1),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .clear_ovf (clear_ovf),
        .req_0     (req_0),
        .req_1     (req_1),
        .pend_0    (pend_0),
        .pend_1    (pend_1),
        .ovf_0     (ovf_0),
        .ovf_1     (ovf_1)
    );

    always #5 clock = ~clock;

    // Registered two-input arbiter, channel 0 has priority; grants are levels.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_0 <= 1'b0;
            gnt_1 <= 1'b0;
        end else if (arb_on) begin
            gnt_0 <= req_0;
            gnt_1 <= req_1 & ~req_0;
        end else begin
            gnt_0 <= gnt_force_0;
            gnt_1 <= gnt_force_1;
        end
    end

    function automatic logic [CNT_W-1:0] pend_of(int ch);
        return (ch == 0) ? pend_0 : pend_1;
    endfunction

    function automatic logic req_of(int ch);
        return (ch == 0) ? req_0 : req_1;
    endfunction

    function automatic logic ovf_of(int ch);
        return (ch == 0) ? ovf_0 : ovf_1;
    endfunction

    function automatic void model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_pend[ch]      = 0;
            m_pend_prev[ch] = 0;
            m_ovf[ch]       = 1'b0;
            prev_s[ch]      = 1'b0;
            req_seen[ch]    = 1'b0;
            since_acc[ch]   = 0;
            acc_cnt[ch]     = 0;
        end
        acc_q.delete();
    endfunction

    task automatic do_reset();
        reset       = 1'b1;
        strobe_0    = 1'b0;
        strobe_1    = 1'b0;
        clear_ovf   = 1'b0;
        arb_on      = 1'b1;
        gnt_force_0 = 1'b0;
        gnt_force_1 = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Called at a negedge: predicts what the coming edge does, drives inputs,
    // then waits for the following negedge. A grant is a real accept only when
    // the request was already up at the previous edge.
    task automatic advance(input bit s0, input bit s1, input bit clr);
        bit s[2];
        bit r[2];
        bit g[2];
        bit e;
        bit a;
        s[0] = s0;
        s[1] = s1;
        r[0] = req_0;
        r[1] = req_1;
        g[0] = gnt_0;
        g[1] = gnt_1;
        for (int ch = 0; ch < 2; ch++) begin
            e = s[ch] & ~prev_s[ch];
            a = r[ch] & g[ch] & req_seen[ch];
            m_pend_prev[ch] = m_pend[ch];
            if (a) begin
                acc_q.push_back(ch);
                acc_cnt[ch]++;
                since_acc[ch] = 1;
            end else if (since_acc[ch] != 0 && since_acc[ch] < 1000) begin
                since_acc[ch]++;
            end
            if (clr) m_ovf[ch] = 1'b0;
            if (e && !a) begin
                if (m_pend[ch] < PMAX) m_pend[ch]++;
                else m_ovf[ch] = 1'b1;
            end else if (a && !e) begin
                m_pend[ch]--;
            end
            req_seen[ch] = r[ch];
            prev_s[ch]   = s[ch];
        end
        strobe_0  = s0;
        strobe_1  = s1;
        clear_ovf = clr;
        @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        @(negedge clock);
        checks++; if (req_0 !== 1'b0) begin fails++; $display("[TB] FAIL reset.req_0: got %0d expected 0", req_0); end
        checks++; if (req_1 !== 1'b0) begin fails++; $display("[TB] FAIL reset.req_1: got %0d expected 0", req_1); end
        checks++; if (pend_0 !== 4'd0) begin fails++; $display("[TB] FAIL reset.pend_0: got %0d expected 0", pend_0); end
        checks++; if (pend_1 !== 4'd0) begin fails++; $display("[TB] FAIL reset.pend_1: got %0d expected 0", pend_1); end
        checks++; if (ovf_0 !== 1'b0) begin fails++; $display("[TB] FAIL reset.ovf_0: got %0d expected 0", ovf_0); end
        checks++; if (ovf_1 !== 1'b0) begin fails++; $display("[TB] FAIL reset.ovf_1: got %0d expected 0", ovf_1); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_event();
        int req_high;
        logic [CNT_W-1:0] exp_pend;
        logic exp_req;
        do_reset();
        req_high = 0;
        for (int k = 0; k < 10; k++) begin
            advance(k == 0, 1'b0, 1'b0);
            exp_pend = (k <= 2) ? 4'd1 : 4'd0;
            exp_req  = (k == 1 || k == 2);
            if (req_0 === 1'b1) req_high++;
            checks++;
            if (pend_0 !== exp_pend) begin
                fails++; $display("[TB] FAIL single.pend_0 k=%0d: got %0d expected %0d", k, pend_0, exp_pend);
            end
            checks++;
            if (req_0 !== exp_req) begin
                fails++; $display("[TB] FAIL single.req_0 k=%0d: got %0d expected %0d", k, req_0, exp_req);
            end
        end
        checks++; if (req_high != 2) begin fails++; $display("[TB] FAIL single.req_cycles: got %0d expected 2", req_high); end
        checks++; if (acc_cnt[0] != 1) begin fails++; $display("[TB] FAIL single.accepts: got %0d expected 1", acc_cnt[0]); end
        checks++; if (ovf_0 !== 1'b0) begin fails++; $display("[TB] FAIL single.ovf_0: got %0d expected 0", ovf_0); end
    endtask

    task automatic test_fairness();
        bit s;
        int got;
        do_reset();
        for (int k = 0; k < 45; k++) begin
            s = (k == 0 || k == 2 || k == 4);
            advance(s, s, 1'b0);
            for (int ch = 0; ch < 2; ch++) begin
                checks++;
                if (pend_of(ch) !== CNT_W'(m_pend[ch])) begin
                    fails++; $display("[TB] FAIL fair.pend_%0d k=%0d: got %0d expected %0d", ch, k, pend_of(ch), m_pend[ch]);
                end
            end
        end
        checks++;
        if (acc_q.size() != 6) begin
            fails++; $display("[TB] FAIL fair.accept_count: got %0d expected 6", acc_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : -1;
            checks++;
            if (got != i % 2) begin
                fails++; $display("[TB] FAIL fair.order[%0d]: got channel %0d expected %0d", i, got, i % 2);
            end
        end
        checks++; if (pend_0 !== 4'd0) begin fails++; $display("[TB] FAIL fair.final_pend_0: got %0d expected 0", pend_0); end
        checks++; if (pend_1 !== 4'd0) begin fails++; $display("[TB] FAIL fair.final_pend_1: got %0d expected 0", pend_1); end
    endtask

    task automatic test_random();
        bit s0;
        bit s1;
        bit clr;
        do_reset();
        for (int k = 0; k < 450; k++) begin
            if (k < 300) begin
                s0  = 1'($urandom_range(0, 1));
                s1  = 1'($urandom_range(0, 1));
                clr = ($urandom_range(0, 15) == 0);
            end else begin
                s0  = 1'b0;
                s1  = 1'b0;
                clr = 1'b0;
            end
            advance(s0, s1, clr);
            for (int ch = 0; ch < 2; ch++) begin
                checks++;
                if (pend_of(ch) !== CNT_W'(m_pend[ch])) begin
                    fails++; $display("[TB] FAIL rand.pend_%0d k=%0d: got %0d expected %0d", ch, k, pend_of(ch), m_pend[ch]);
                end
                checks++;
                if (ovf_of(ch) !== m_ovf[ch]) begin
                    fails++; $display("[TB] FAIL rand.ovf_%0d k=%0d: got %0d expected %0d", ch, k, ovf_of(ch), m_ovf[ch]);
                end
                if (since_acc[ch] >= 1 && since_acc[ch] <= 3) begin
                    checks++;
                    if (req_of(ch) !== 1'b0) begin
                        fails++; $display("[TB] FAIL rand.holdoff_req_%0d k=%0d: got %0d expected 0", ch, k, req_of(ch));
                    end
                end else if (since_acc[ch] == 4) begin
                    checks++;
                    if (req_of(ch) !== (m_pend_prev[ch] != 0)) begin
                        fails++; $display("[TB] FAIL rand.rerequest_%0d k=%0d: got %0d expected %0d", ch, k, req_of(ch), (m_pend_prev[ch] != 0));
                    end
                end
            end
        end
        checks++; if (pend_0 !== 4'd0) begin fails++; $display("[TB] FAIL rand.drain_pend_0: got %0d expected 0", pend_0); end
        checks++; if (pend_1 !== 4'd0) begin fails++; $display("[TB] FAIL rand.drain_pend_1: got %0d expected 0", pend_1); end
    endtask

    task automatic test_saturation();
        do_reset();
        arb_on = 1'b0;
        for (int i = 0; i < 16; i++) begin
            advance(1'b0, 1'b1, 1'b0);
            if (i == 14) begin
                checks++; if (pend_1 !== 4'd15) begin fails++; $display("[TB] FAIL sat.pend_1_at_15: got %0d expected 15", pend_1); end
                checks++; if (ovf_1 !== 1'b0) begin fails++; $display("[TB] FAIL sat.ovf_1_at_15: got %0d expected 0", ovf_1); end
            end
            advance(1'b0, 1'b0, 1'b0);
        end
        checks++; if (pend_1 !== 4'd15) begin fails++; $display("[TB] FAIL sat.pend_1_at_16: got %0d expected 15", pend_1); end
        checks++; if (ovf_1 !== 1'b1) begin fails++; $display("[TB] FAIL sat.ovf_1_at_16: got %0d expected 1", ovf_1); end
        checks++; if (ovf_0 !== 1'b0) begin fails++; $display("[TB] FAIL sat.ovf_0_isolated: got %0d expected 0", ovf_0); end
        advance(1'b0, 1'b0, 1'b1);
        checks++; if (ovf_1 !== 1'b0) begin fails++; $display("[TB] FAIL sat.ovf_1_cleared: got %0d expected 0", ovf_1); end
        checks++; if (pend_1 !== 4'd15) begin fails++; $display("[TB] FAIL sat.pend_1_after_clear: got %0d expected 15", pend_1); end
        advance(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_edge_and_accept();
        do_reset();
        arb_on = 1'b0;
        for (int i = 0; i < 15; i++) begin
            advance(1'b1, 1'b0, 1'b0);
            advance(1'b0, 1'b0, 1'b0);
        end
        checks++; if (pend_0 !== 4'd15) begin fails++; $display("[TB] FAIL ea.pend_0_full: got %0d expected 15", pend_0); end
        checks++; if (req_0 !== 1'b1) begin fails++; $display("[TB] FAIL ea.req_0_up: got %0d expected 1", req_0); end
        gnt_force_0 = 1'b1;
        advance(1'b0, 1'b0, 1'b0);
        gnt_force_0 = 1'b0;
        advance(1'b1, 1'b0, 1'b0);
        checks++; if (pend_0 !== 4'd15) begin fails++; $display("[TB] FAIL ea.pend_0: got %0d expected 15", pend_0); end
        checks++; if (ovf_0 !== 1'b0) begin fails++; $display("[TB] FAIL ea.ovf_0: got %0d expected 0", ovf_0); end
        checks++; if (req_0 !== 1'b0) begin fails++; $display("[TB] FAIL ea.req_0_dropped: got %0d expected 0", req_0); end
        checks++; if (acc_cnt[0] != 1) begin fails++; $display("[TB] FAIL ea.accepts: got %0d expected 1", acc_cnt[0]); end
        advance(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stale_grant();
        logic [CNT_W-1:0] exp_pend;
        logic exp_req;
        do_reset();
        arb_on      = 1'b0;
        gnt_force_1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            advance(1'b0, 1'b0, 1'b0);
            checks++;
            if (pend_1 !== 4'd0 || req_1 !== 1'b0) begin
                fails++; $display("[TB] FAIL stale.idle k=%0d: got pend %0d req %0d expected pend 0 req 0", k, pend_1, req_1);
            end
        end
        for (int k = 0; k < 6; k++) begin
            advance(1'b0, k == 0, 1'b0);
            exp_pend = (k <= 2) ? 4'd1 : 4'd0;
            exp_req  = (k == 1 || k == 2);
            checks++;
            if (pend_1 !== exp_pend) begin
                fails++; $display("[TB] FAIL stale.pend_1 k=%0d: got %0d expected %0d", k, pend_1, exp_pend);
            end
            checks++;
            if (req_1 !== exp_req) begin
                fails++; $display("[TB] FAIL stale.req_1 k=%0d: got %0d expected %0d", k, req_1, exp_req);
            end
        end
        checks++; if (acc_cnt[1] != 1) begin fails++; $display("[TB] FAIL stale.accepts: got %0d expected 1", acc_cnt[1]); end
        gnt_force_1 = 1'b0;
        advance(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        arb_on = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance(1'b1, 1'b0, 1'b0);
            advance(1'b0, 1'b0, 1'b0);
        end
        checks++; if (pend_0 !== 4'd3) begin fails++; $display("[TB] FAIL rmid.pend_0_before: got %0d expected 3", pend_0); end
        checks++; if (req_0 !== 1'b1) begin fails++; $display("[TB] FAIL rmid.req_0_before: got %0d expected 1", req_0); end
        strobe_0 = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (req_0 !== 1'b0) begin fails++; $display("[TB] FAIL rmid.req_0_async: got %0d expected 0", req_0); end
        checks++; if (pend_0 !== 4'd0) begin fails++; $display("[TB] FAIL rmid.pend_0_async: got %0d expected 0", pend_0); end
        checks++; if (ovf_0 !== 1'b0) begin fails++; $display("[TB] FAIL rmid.ovf_0_async: got %0d expected 0", ovf_0); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        advance(1'b1, 1'b0, 1'b0);
        checks++; if (pend_0 !== 4'd1) begin fails++; $display("[TB] FAIL rmid.pend_0_first_edge: got %0d expected 1", pend_0); end
        advance(1'b1, 1'b0, 1'b0);
        advance(1'b1, 1'b0, 1'b0);
        checks++; if (pend_0 !== 4'd1) begin fails++; $display("[TB] FAIL rmid.pend_0_held: got %0d expected 1", pend_0); end
        checks++; if (req_0 !== 1'b1) begin fails++; $display("[TB] FAIL rmid.req_0_after: got %0d expected 1", req_0); end
    endtask

    initial begin
        reset       = 1'b1;
        strobe_0    = 1'b0;
        strobe_1    = 1'b0;
        clear_ovf   = 1'b0;
        arb_on      = 1'b1;
        gnt_force_0 = 1'b0;
        gnt_force_1 = 1'b0;
        model_reset();
        test_reset();
        test_single_event();
        test_fairness();
        test_random();
        test_saturation();
        test_edge_and_accept();
        test_stale_grant();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
